line_rasterizer: RTL and testbench

//  Downstream of the vector-generator line queue. Pops one segment (start/end, intensity) when the queue is non-empty.

---
 rtl/line_rasterizer_pkg.sv | 22 ++
 rtl/line_rasterizer_if.sv | 41 ++++
 rtl/line_rasterizer_coord_map.sv | 36 +++
 rtl/line_rasterizer.sv | 188 ++++++++++++++++++
 tb/tb_line_rasterizer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/line_rasterizer_pkg.sv
// ============================================================================
// Module : avg_pkg
// Brief  : Shared types and constants for the line rasterizer slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package avg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } rast_state_t;

    localparam int c_SCREEN_W = 640;
    localparam int c_SCREEN_H = 480;
    localparam int c_INT_W    = 4;

endpackage

`default_nettype wire

// File: rtl/line_rasterizer_if.sv
// ============================================================================
// Module : line_rasterizer_if
// Brief  : Segment-queue pop link and framebuffer pixel link of the rasterizer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface line_rasterizer_if #(
    parameter int COORD_W = 13,
    parameter int PIX_W   = 10
) ();
    import avg_pkg::*;

    logic signed [COORD_W-1:0] lnStartX;
    logic signed [COORD_W-1:0] lnStartY;
    logic signed [COORD_W-1:0] lnEndX;
    logic signed [COORD_W-1:0] lnEndY;
    logic [c_INT_W-1:0]        lnIntensity;
    logic                      lnEmpty;
    logic                      lnRead;
    logic [PIX_W-1:0]          pixX;
    logic [PIX_W-1:0]          pixY;
    logic [c_INT_W-1:0]        pixIntensity;
    logic                      pixValid;
    logic                      pixReady;
    logic                      busy;
    logic                      lineDone;

    modport master (
        input  lnStartX, lnStartY, lnEndX, lnEndY, lnIntensity, lnEmpty, pixReady,
        output lnRead, pixX, pixY, pixIntensity, pixValid, busy, lineDone
    );

    modport slave (
        output lnStartX, lnStartY, lnEndX, lnEndY, lnIntensity, lnEmpty, pixReady,
        input  lnRead, pixX, pixY, pixIntensity, pixValid, busy, lineDone
    );

endinterface

`default_nettype wire

// File: rtl/line_rasterizer_coord_map.sv
// ============================================================================
// Module : line_coord_map
// Brief  : Combinational map of one signed centred point to screen pixel space.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module line_coord_map #(
    parameter int COORD_W  = 13,
    parameter int PIX_W    = 10,
    parameter int SHIFT    = 3,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  wire logic signed [COORD_W-1:0] x_i,
    input  wire logic signed [COORD_W-1:0] y_i,
    output logic signed [PIX_W+1:0]        px_o,
    output logic signed [PIX_W+1:0]        py_o
);
    localparam int PW = PIX_W + 2;
    localparam logic signed [PW-1:0] c_HALF_W = PW'(SCREEN_W / 2);
    localparam logic signed [PW-1:0] c_HALF_H = PW'(SCREEN_H / 2);

    logic signed [COORD_W-1:0] w_xs;
    logic signed [COORD_W-1:0] w_ys;

    assign w_xs = x_i >>> SHIFT;
    assign w_ys = y_i >>> SHIFT;

    // Screen y grows downward, so the centred y axis is inverted.
    assign px_o = PW'(w_xs) + c_HALF_W;
    assign py_o = c_HALF_H - PW'(w_ys);

endmodule

`default_nettype wire

// File: rtl/line_rasterizer.sv
// ============================================================================
// Module : line_rasterizer
// Brief  : Pops segments, maps them to pixel space and walks them with
//          Bresenham, one pixel per cycle. Optional clipping: LINE_RASTER_CLIP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module line_rasterizer
    import avg_pkg::*;
#(
    parameter int COORD_W  = 13,
    parameter int PIX_W    = 10,
    parameter int SHIFT    = 3,
    parameter int SCREEN_W = c_SCREEN_W,
    parameter int SCREEN_H = c_SCREEN_H
) (
    input  wire logic          clk,
    input  wire logic          rst,
    line_rasterizer_if.master  bus
);
    localparam int PW = PIX_W + 2;
    localparam int EW = PIX_W + 3;
    localparam logic signed [PW-1:0] c_ONE   = PW'(1);
    localparam logic signed [EW-1:0] c_EZERO = '0;

    rast_state_t state_q, state_d;

    logic signed [COORD_W-1:0] hx0_q, hy0_q, hx1_q, hy1_q;
    logic signed [COORD_W-1:0] hx0_d, hy0_d, hx1_d, hy1_d;
    logic [c_INT_W-1:0]        int_q, int_d;
    logic signed [PW-1:0]      x_q, y_q, xe_q, ye_q;
    logic signed [PW-1:0]      x_d, y_d, xe_d, ye_d;
    logic signed [EW-1:0]      dx_q, dy_q, err_q;
    logic signed [EW-1:0]      dx_d, dy_d, err_d;
    logic                      sxn_q, syn_q, sxn_d, syn_d;
    logic                      lineDone_q, lineDone_d;

    logic signed [PW-1:0] w_px0, w_py0, w_px1, w_py1;
    logic signed [EW-1:0] w_ddx, w_ddy, w_adx, w_ady;
    logic signed [EW:0]   w_e2;
    logic                 w_pop, w_emit, w_adv, w_at_end;

    line_coord_map #(
        .COORD_W(COORD_W), .PIX_W(PIX_W), .SHIFT(SHIFT),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) u_map_start (
        .x_i(hx0_q), .y_i(hy0_q), .px_o(w_px0), .py_o(w_py0)
    );

    line_coord_map #(
        .COORD_W(COORD_W), .PIX_W(PIX_W), .SHIFT(SHIFT),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) u_map_end (
        .x_i(hx1_q), .y_i(hy1_q), .px_o(w_px1), .py_o(w_py1)
    );

`ifdef LINE_RASTER_CLIP_EN
    localparam logic signed [PW-1:0] c_ZERO = '0;
    localparam logic signed [PW-1:0] c_SW   = PW'(SCREEN_W);
    localparam logic signed [PW-1:0] c_SH   = PW'(SCREEN_H);
    assign w_emit = (x_q >= c_ZERO) && (x_q < c_SW) && (y_q >= c_ZERO) && (y_q < c_SH);
`else
    assign w_emit = 1'b1;
`endif

    assign w_ddx    = EW'(w_px1) - EW'(w_px0);
    assign w_ddy    = EW'(w_py1) - EW'(w_py0);
    assign w_adx    = (w_ddx < c_EZERO) ? -w_ddx : w_ddx;
    assign w_ady    = (w_ddy < c_EZERO) ? -w_ddy : w_ddy;
    assign w_e2     = {err_q, 1'b0};
    assign w_pop    = (state_q == IDLE) && !bus.lnEmpty;
    // Off-screen pixels are skipped without waiting on the framebuffer.
    assign w_adv    = (state_q == DRAW) && (!w_emit || bus.pixReady);
    assign w_at_end = (x_q == xe_q) && (y_q == ye_q);

    assign bus.lnRead       = w_pop && !rst;
    assign bus.pixValid     = (state_q == DRAW) && w_emit;
    assign bus.pixX         = x_q[PIX_W-1:0];
    assign bus.pixY         = y_q[PIX_W-1:0];
    assign bus.pixIntensity = int_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.lineDone     = lineDone_q;

    always_comb begin
        state_d    = state_q;
        hx0_d      = hx0_q;
        hy0_d      = hy0_q;
        hx1_d      = hx1_q;
        hy1_d      = hy1_q;
        int_d      = int_q;
        x_d        = x_q;
        y_d        = y_q;
        xe_d       = xe_q;
        ye_d       = ye_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        err_d      = err_q;
        sxn_d      = sxn_q;
        syn_d      = syn_q;
        lineDone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_pop) begin
                    hx0_d   = bus.lnStartX;
                    hy0_d   = bus.lnStartY;
                    hx1_d   = bus.lnEndX;
                    hy1_d   = bus.lnEndY;
                    int_d   = bus.lnIntensity;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                x_d   = w_px0;
                y_d   = w_py0;
                xe_d  = w_px1;
                ye_d  = w_py1;
                dx_d  = w_adx;
                dy_d  = -w_ady;
                err_d = w_adx - w_ady;
                sxn_d = (w_ddx < c_EZERO);
                syn_d = (w_ddy < c_EZERO);
                if (int_q == '0) begin
                    lineDone_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (w_adv) begin
                    if (w_at_end) begin
                        lineDone_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        // Both axis decisions use the error term from before this step.
                        err_d = err_q + ((w_e2 >= dy_q) ? dy_q : c_EZERO)
                                      + ((w_e2 <= dx_q) ? dx_q : c_EZERO);
                        if (w_e2 >= dy_q) x_d = sxn_q ? (x_q - c_ONE) : (x_q + c_ONE);
                        if (w_e2 <= dx_q) y_d = syn_q ? (y_q - c_ONE) : (y_q + c_ONE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hx0_q      <= '0;
            hy0_q      <= '0;
            hx1_q      <= '0;
            hy1_q      <= '0;
            int_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            xe_q       <= '0;
            ye_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            err_q      <= '0;
            sxn_q      <= 1'b0;
            syn_q      <= 1'b0;
            lineDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hx0_q      <= hx0_d;
            hy0_q      <= hy0_d;
            hx1_q      <= hx1_d;
            hy1_q      <= hy1_d;
            int_q      <= int_d;
            x_q        <= x_d;
            y_q        <= y_d;
            xe_q       <= xe_d;
            ye_q       <= ye_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            err_q      <= err_d;
            sxn_q      <= sxn_d;
            syn_q      <= syn_d;
            lineDone_q <= lineDone_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_rasterizer.sv
// ============================================================================
// Module : tb_line_rasterizer
// Brief  : Directed self-checking bench for line_rasterizer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_line_rasterizer;
    import avg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_rasterizer_if #(.COORD_W(13), .PIX_W(10)) bus ();

    line_rasterizer #(
        .COORD_W(13), .PIX_W(10), .SHIFT(3), .SCREEN_W(640), .SCREEN_H(480)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Segment queue model feeding the DUT head
    logic signed [12:0] qsx [16];
    logic signed [12:0] qsy [16];
    logic signed [12:0] qex [16];
    logic signed [12:0] qey [16];
    logic [3:0]         qin [16];
    int head = 0;
    int tail = 0;

    assign bus.lnStartX    = qsx[head[3:0]];
    assign bus.lnStartY    = qsy[head[3:0]];
    assign bus.lnEndX      = qex[head[3:0]];
    assign bus.lnEndY      = qey[head[3:0]];
    assign bus.lnIntensity = qin[head[3:0]];
    assign bus.lnEmpty     = (head == tail);

    always @(posedge clk) if (bus.lnRead) head <= head + 1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int px[$];
    int py[$];
    int pi[$];
    int pc[$];
    int nrd = 0, nld = 0, rd_cyc = 0, ld_cyc = 0, viol = 0;

    always @(negedge clk) begin
        if (bus.pixValid && bus.pixReady) begin
            px.push_back(int'(bus.pixX));
            py.push_back(int'(bus.pixY));
            pi.push_back(int'(bus.pixIntensity));
            pc.push_back(cyc);
        end
        if (bus.lnRead) begin
            nrd++;
            rd_cyc = cyc;
            if (bus.lnEmpty) viol++;
        end
        if (bus.lineDone) begin
            nld++;
            ld_cyc = cyc;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int sx, input int sy, input int ex, input int ey, input int in);
        qsx[tail[3:0]] = 13'(sx);
        qsy[tail[3:0]] = 13'(sy);
        qex[tail[3:0]] = 13'(ex);
        qey[tail[3:0]] = 13'(ey);
        qin[tail[3:0]] = 4'(in);
        tail++;
    endtask

    task automatic clr();
        px.delete(); py.delete(); pi.delete(); pc.delete();
        nrd = 0;
        nld = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (nld < 1 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({tag, "_done_in_time"}, longint'(nld >= 1), 1);
    endtask

    initial begin
        int errs;
        int last;
        int n;

        bus.pixReady = 1'b1;
        tick(3);
        chk("rst_pixValid", bus.pixValid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_lineDone", bus.lineDone, 0);
        chk("rst_pixX", bus.pixX, 0);
        chk("rst_pixY", bus.pixY, 0);
        push(0, 0, 80, 0, 7);
        tick(1);
        chk("rst_lnRead_gated", bus.lnRead, 0);

        // Horizontal line
        clr();
        rst = 1'b0;
        wait_done("t1", 200);
        chk("t1_beats", px.size(), 11);
        chk("t1_reads", nrd, 1);
        errs = 0;
        for (int i = 0; i < px.size() && i < 11; i++) begin
            if (px[i] != 320 + i || py[i] != 240 || pi[i] != 7 || pc[i] != pc[0] + i) errs++;
        end
        chk("t1_pixels", errs, 0);
        if (px.size() == 11) begin
            chk("t1_latency", pc[0] - rd_cyc, 2);
            chk("t1_done_after_last", ld_cyc - pc[10], 1);
        end

        // Steep line
        clr();
        push(0, 0, 16, 40, 9);
        wait_done("t2", 100);
        chk("t2_beats", px.size(), 6);
        begin
            int ex[6] = '{320, 320, 321, 321, 322, 322};
            int ey[6] = '{240, 239, 238, 237, 236, 235};
            for (int i = 0; i < px.size() && i < 6; i++) begin
                chk("t2_x", px[i], ex[i]);
                chk("t2_y", py[i], ey[i]);
            end
        end

        // Backpressure on the fourth beat
        clr();
        push(0, 0, 80, 0, 7);
        n = 0;
        while (px.size() < 3 && n < 50) begin
            tick(1);
            n++;
        end
        chk("t3_reach_beat4", longint'(px.size()), 3);
        bus.pixReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", bus.pixValid, 1);
            chk("t3_hold_x", bus.pixX, 323);
            chk("t3_hold_y", bus.pixY, 240);
        end
        tick(1);
        bus.pixReady = 1'b1;
        wait_done("t3", 100);
        chk("t3_beats", px.size(), 11);
        errs = 0;
        for (int i = 0; i < px.size() && i < 11; i++) if (px[i] != 320 + i || py[i] != 240) errs++;
        chk("t3_pixels", errs, 0);

        // Single-point segment
        clr();
        push(8, 8, 8, 8, 2);
        wait_done("t4p", 50);
        tick(3);
        chk("t4_point_beats", px.size(), 1);
        if (px.size() >= 1) begin
            chk("t4_point_x", px[0], 321);
            chk("t4_point_y", py[0], 239);
            chk("t4_point_int", pi[0], 2);
        end

        // Zero-intensity segment is dropped
        clr();
        push(8, 8, 100, 100, 0);
        wait_done("t4z", 50);
        tick(3);
        chk("t4_zero_beats", px.size(), 0);
        chk("t4_zero_reads", nrd, 1);
        chk("t4_zero_done_lat", ld_cyc - rd_cyc, 2);

        // Long line starting far left of the screen
        clr();
        push(-4000, 0, 0, 0, 4);
        wait_done("t5", 800);
        errs = 0;
        for (int i = 0; i < py.size(); i++) if (py[i] != 240) errs++;
        chk("t5_y", errs, 0);
        last = px.size() - 1;
`ifdef LINE_RASTER_CLIP_EN
        chk("t5_beats", px.size(), 321);
        if (px.size() == 321) chk("t5_first_x", px[0], 0);
`else
        chk("t5_beats", px.size(), 501);
        if (px.size() == 501) begin
            chk("t5_first_x_wrapped", px[0], 844);
            chk("t5_x_at_180", px[180], 0);
        end
`endif
        if (last >= 0) begin
            chk("t5_last_x", px[last], 320);
            chk("t5_walk_span", pc[last] - rd_cyc, 502);
        end

        // Reset mid-line with a second segment queued
        clr();
        push(0, 0, 80, 0, 3);
        push(0, 0, 0, -16, 5);
        n = 0;
        while (px.size() < 4 && n < 50) begin
            tick(1);
            n++;
        end
        chk("t6_reach_mid", longint'(px.size() >= 4), 1);
        rst = 1'b1;
        #1;
        chk("t6_valid_drop", bus.pixValid, 0);
        chk("t6_busy_drop", bus.busy, 0);
        clr();
        tick(2);
        rst = 1'b0;
        wait_done("t6", 100);
        chk("t6_reads", nrd, 1);
        chk("t6_beats", px.size(), 3);
        errs = 0;
        for (int i = 0; i < px.size() && i < 3; i++) if (px[i] != 320 || py[i] != 240 + i || pi[i] != 5) errs++;
        chk("t6_pixels", errs, 0);
        tick(3);
        chk("t6_queue_drained", longint'(head == tail), 1);
        chk("pop_while_empty", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
